// File: rtl/instr_encoder_pkg.sv
// Shared encoding constants for the MIPS control encoder/decoder.
// Opcodes, functs, ALU-op codes, FSM states, control bundle type.
package instr_encoder_pkg;

  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_NOR = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_TERM = 2'd2,
    ST_DONE = 2'd3
  } enc_state_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        alu_source;
    logic        alu_source_shift;
    logic        reg_dst;
    logic [3:0]  alu_control;
    logic        variant;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
  } ctrl_t;

  function automatic logic [31:0] itype(
    input logic [5:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [15:0] imm
  );
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic [4:0] rd,
    input logic [4:0] shamt,
    input logic [5:0] funct
  );
    return {OP_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request channel of the encoder: valid/ready plus control bundle.
// master = bundle source (loader/bench), slave = instr_encoder.
interface instr_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic        reg_write;
  logic        mem_to_reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic        alu_source;
  logic        alu_source_shift;
  logic        reg_dst;
  logic [3:0]  alu_control;
  logic        variant;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;

  modport master (
    output req_valid, reg_write, mem_to_reg_write,
    output mem_read, mem_write, branch, alu_source,
    output alu_source_shift, reg_dst, alu_control,
    output variant, rs, rt, rd, shamt, imm,
    input  req_ready
  );

  modport slave (
    input  req_valid, reg_write, mem_to_reg_write,
    input  mem_read, mem_write, branch, alu_source,
    input  alu_source_shift, reg_dst, alu_control,
    input  variant, rs, rt, rd, shamt, imm,
    output req_ready
  );
endinterface

// File: rtl/instr_encode_comb.sv
// Pure combinational control bundle -> 32-bit MIPS word.
// In: c (ctrl_t). Out: word, illegal (bundle not encodable).
module instr_encode_comb
  import instr_encoder_pkg::*;
(
  input  ctrl_t       c,
  output logic [31:0] word,
  output logic        illegal
);

  logic [5:0] funct;
  logic       funct_ok;
  logic [5:0] iop;
  logic       iop_ok;
  logic       is_shift;
  logic       shift_imm;
  logic [4:0] rs_f;
  logic [4:0] sh_f;

  always_comb begin
    funct    = '0;
    funct_ok = 1'b1;
    unique case (c.alu_control)
      ALU_ADD: funct = c.variant ? F_ADDU : F_ADD;
      ALU_SUB: funct = c.variant ? F_SUBU : F_SUB;
      ALU_AND: begin funct = F_AND; funct_ok = !c.variant; end
      ALU_OR:  begin funct = F_OR;  funct_ok = !c.variant; end
      ALU_XOR: begin funct = F_XOR; funct_ok = !c.variant; end
      ALU_NOR: begin funct = F_NOR; funct_ok = !c.variant; end
      ALU_SLT: begin funct = F_SLT; funct_ok = !c.variant; end
      ALU_SLL: funct = c.variant ? F_SLLV : F_SLL;
      ALU_SRL: funct = c.variant ? F_SRLV : F_SRL;
      ALU_SRA: funct = c.variant ? F_SRAV : F_SRA;
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    iop    = '0;
    iop_ok = 1'b1;
    unique case (c.alu_control)
      ALU_ADD: iop = c.variant ? OP_ADDIU : OP_ADDI;
      ALU_AND: iop = OP_ANDI;
      ALU_OR:  iop = OP_ORI;
      ALU_XOR: iop = OP_XORI;
      default: iop_ok = 1'b0;
    endcase
  end

  // Immediate shifts carry shamt and zero rs; everything
  // else in R-format zeroes shamt.
  assign is_shift  = (c.alu_control == ALU_SLL)
                  || (c.alu_control == ALU_SRL)
                  || (c.alu_control == ALU_SRA);
  assign shift_imm = is_shift && !c.variant;
  assign rs_f      = shift_imm ? 5'd0 : c.rs;
  assign sh_f      = shift_imm ? c.shamt : 5'd0;

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    if (c.branch && c.alu_control == ALU_SUB) begin
      word = itype(c.variant ? OP_BNE : OP_BEQ,
                   c.rs, c.rt, c.imm);
    end else if (c.mem_write && c.alu_source
              && c.alu_control == ALU_ADD
              && !c.reg_write) begin
      word = itype(OP_SW, c.rs, c.rt, c.imm);
    end else if (c.mem_read && c.mem_to_reg_write
              && c.reg_write && c.alu_source
              && c.alu_control == ALU_ADD) begin
      word = itype(OP_LW, c.rs, c.rt, c.imm);
    end else if (c.reg_write && c.alu_source
              && !c.reg_dst) begin
      word    = itype(iop, c.rs, c.rt, c.imm);
      illegal = !iop_ok;
    end else if (c.reg_write && !c.alu_source
              && c.reg_dst) begin
      word    = rtype(rs_f, c.rt, c.rd, sh_f, funct);
      // shift source select must agree with variant
      illegal = !funct_ok
             || (is_shift
                 && (c.alu_source_shift == c.variant));
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded control bundles into imem, then a HALT word.
// clk/reset; start+base_addr, finish; req (slave); imem_we/addr/wdata;
// err_illegal, state_o, word_count.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  instr_encoder_if.slave    req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              err_illegal,
  output logic [1:0]        state_o,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              room_q, room_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;

  ctrl_t       ctrl;
  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        ready;
  logic        accept;

  assign ctrl = '{
    reg_write:        req.reg_write,
    mem_to_reg_write: req.mem_to_reg_write,
    mem_read:         req.mem_read,
    mem_write:        req.mem_write,
    branch:           req.branch,
    alu_source:       req.alu_source,
    alu_source_shift: req.alu_source_shift,
    reg_dst:          req.reg_dst,
    alu_control:      req.alu_control,
    variant:          req.variant,
    rs:               req.rs,
    rt:               req.rt,
    rd:               req.rd,
    shamt:            req.shamt,
    imm:              req.imm
  };

  instr_encode_comb u_enc (
    .c       (ctrl),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // finish has priority over a same-cycle bundle
  assign ready  = (state_q == ST_LOAD) && !finish && room_q;
  assign accept = req.req_valid && ready;

  assign req.req_ready = ready;
  assign imem_we       = we_q;
  assign imem_addr     = addr_q;
  assign imem_wdata    = wdata_q;
  assign err_illegal   = err_q;
  assign state_o       = state_q;
  assign word_count    = count_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    room_d  = room_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          ptr_d   = base_addr;
          room_d  = 1'b1;
          count_d = '0;
        end
      end
      ST_LOAD: begin
        if (finish) begin
          state_d = ST_TERM;
        end else if (accept) begin
          if (enc_illegal) begin
            err_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = enc_word;
            count_d = count_q + CNT_ONE;
            // top word used: no room for more, not even HALT
            if (ptr_q == ADDR_MAX) begin
              room_d  = 1'b0;
              state_d = ST_TERM;
            end else begin
              ptr_d = ptr_q + ADDR_ONE;
            end
          end
        end
      end
      ST_TERM: begin
        state_d = ST_DONE;
        if (room_q) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = HALT_WORD;
          count_d = count_q + CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      room_q  <= 1'b0;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      room_q  <= room_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder.
// Directed cases plus a random stream against a mnemonic table model.
module tb_instr_encoder;

  localparam int AW = 8;

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic        mr;
    logic        mw;
    logic        br;
    logic        asrc;
    logic        ashift;
    logic        rdst;
    logic [3:0]  alu;
    logic        vr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [15:0] imm;
  } bnd_t;

  // {bad, class, alu, variant, code}: class 0=R 1=I 2=lw
  // 3=sw 4=branch 6=empty bundle
  localparam logic [23:0] TAB [29] = '{
    24'h001020, 24'h001121, 24'h002022, 24'h002123,
    24'h003024, 24'h004025, 24'h005026, 24'h006027,
    24'h00702a, 24'h008000, 24'h009002, 24'h00a003,
    24'h008104, 24'h009106, 24'h00a107, 24'h011008,
    24'h011109, 24'h01300c, 24'h01400d, 24'h01500e,
    24'h021023, 24'h03102b, 24'h042004, 24'h042105,
    24'h141004, 24'h103124, 24'h108000, 24'h160000,
    24'h112008
  };

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          finish;
  logic [AW-1:0] base_addr;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          err_illegal;
  logic [1:0]    state_o;
  logic [AW:0]   word_count;

  instr_encoder_if bus ();

  instr_encoder #(
    .ADDR_W    (AW),
    .HALT_WORD (32'hFFFF_FFFF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .finish      (finish),
    .req         (bus),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .err_illegal (err_illegal),
    .state_o     (state_o),
    .word_count  (word_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_err  = 0;
  logic [39:0] wq [$];

  always @(posedge clk) begin
    if (imem_we) wq.push_back({imem_addr, imem_wdata});
    if (err_illegal) n_err++;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  function automatic void make(
    input  int          k,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  sh,
    input  logic [15:0] imm,
    output bnd_t        b,
    output logic [31:0] w,
    output bit          ok
  );
    logic [23:0] e;
    logic [3:0]  cls;
    logic [3:0]  alu;
    logic        v;
    logic        bad;
    logic        shimm;
    logic [5:0]  code;
    e     = TAB[k];
    bad   = e[20];
    cls   = e[19:16];
    alu   = e[15:12];
    v     = e[8];
    code  = e[5:0];
    shimm = (cls == 0) && (alu >= 8) && !v;
    b     = '0;
    b.alu = alu;
    b.vr  = v;
    b.rs  = rs;
    b.rt  = rt;
    b.rd  = rd;
    b.sh  = sh;
    b.imm = imm;
    ok    = !bad;
    w     = '0;
    case (cls)
      0: begin
        b.rw     = 1'b1;
        b.rdst   = 1'b1;
        b.ashift = shimm ^ (bad && alu >= 8);
      end
      1: begin b.rw = 1'b1; b.asrc = 1'b1; end
      2: begin
        b.rw   = 1'b1;
        b.m2r  = 1'b1;
        b.mr   = 1'b1;
        b.asrc = 1'b1;
      end
      3: begin b.mw = 1'b1; b.asrc = 1'b1; end
      4: b.br = 1'b1;
      default: ;
    endcase
    if (ok) begin
      if (cls == 0)
        w = {6'd0, shimm ? 5'd0 : rs, rt, rd,
             shimm ? sh : 5'd0, code};
      else
        w = {code, rs, rt, imm};
    end
  endfunction

  task automatic drive(input bnd_t b, input logic v);
    bus.req_valid        = v;
    bus.reg_write        = b.rw;
    bus.mem_to_reg_write = b.m2r;
    bus.mem_read         = b.mr;
    bus.mem_write        = b.mw;
    bus.branch           = b.br;
    bus.alu_source       = b.asrc;
    bus.alu_source_shift = b.ashift;
    bus.reg_dst          = b.rdst;
    bus.alu_control      = b.alu;
    bus.variant          = b.vr;
    bus.rs               = b.rs;
    bus.rt               = b.rt;
    bus.rd               = b.rd;
    bus.shamt            = b.sh;
    bus.imm              = b.imm;
  endtask

  task automatic do_start(input logic [AW-1:0] base);
    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    @(negedge clk);
    start = 1'b0;
    check("start_state", state_o, 2'd1);
  endtask

  // call at a negedge; checks the write during cycle N+1
  task automatic push(input string tag, input bnd_t b,
                      input logic [31:0] w, input bit ok,
                      input logic [AW-1:0] a);
    int n;
    n = 0;
    drive(b, 1'b1);
    while (!bus.req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, bus.req_ready, 1'b1);
    @(negedge clk);
    drive(b, 1'b0);
    check({tag, "_we"}, imem_we, ok);
    check({tag, "_err"}, err_illegal, !ok);
    if (ok) begin
      check({tag, "_addr"}, imem_addr, a);
      check({tag, "_data"}, imem_wdata, w);
    end
  endtask

  initial begin
    bnd_t          b;
    logic [31:0]   w;
    bit            ok;
    logic [39:0]   eq [$];
    logic [AW-1:0] a;
    int            exp_err;
    int            err0;
    int            stalls;
    int            k;

    reset     = 1'b1;
    start     = 1'b0;
    finish    = 1'b0;
    base_addr = '0;
    drive('0, 1'b0);
    #2;
    check("rst_state", state_o, 2'd0);
    check("rst_ready", bus.req_ready, 1'b0);
    check("rst_we", imem_we, 1'b0);
    check("rst_err", err_illegal, 1'b0);
    check("rst_addr", imem_addr, 8'h00);
    check("rst_data", imem_wdata, 32'h0);
    check("rst_count", word_count, 9'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    do_start(8'h10);
    make(0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, b, w, ok);
    push("add", b, 32'h0022_1820, 1'b1, 8'h10);
    check("add_count", word_count, 9'd1);
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    check("fin_term", state_o, 2'd2);
    @(negedge clk);
    check("halt_we", imem_we, 1'b1);
    check("halt_addr", imem_addr, 8'h11);
    check("halt_data", imem_wdata, 32'hFFFF_FFFF);
    check("halt_state", state_o, 2'd3);
    check("halt_count", word_count, 9'd2);

    do_start(8'h10);
    check("restart_count", word_count, 9'd0);
    make(20, 5'd5, 5'd4, 5'd0, 5'd0, 16'h0008, b, w, ok);
    push("lw", b, 32'h8CA4_0008, 1'b1, 8'h10);
    make(22, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFE, b, w, ok);
    push("beq", b, 32'h1022_FFFE, 1'b1, 8'h11);
    make(9, 5'd7, 5'd1, 5'd2, 5'd3, 16'h0, b, w, ok);
    push("sll", b, 32'h0001_10C0, 1'b1, 8'h12);
    make(14, 5'd7, 5'd1, 5'd2, 5'd3, 16'h0, b, w, ok);
    push("srav", b, 32'h00E1_1007, 1'b1, 8'h13);

    make(24, 5'd1, 5'd2, 5'd0, 5'd0, 16'h4, b, w, ok);
    push("illegal", b, w, ok, 8'h14);
    @(negedge clk);
    check("illegal_pulse", err_illegal, 1'b0);
    make(2, 5'd9, 5'd10, 5'd11, 5'd4, 16'h0, b, w, ok);
    push("sub_after_ill", b, w, ok, 8'h14);
    check("ill_count", word_count, 9'd5);

    make(0, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, b, w, ok);
    drive(b, 1'b1);
    finish = 1'b1;
    #1;
    check("fin_vs_valid_ready", bus.req_ready, 1'b0);
    @(negedge clk);
    finish = 1'b0;
    drive(b, 1'b0);
    check("fin_vs_valid_we", imem_we, 1'b0);
    @(negedge clk);
    check("fin_halt_addr", imem_addr, 8'h15);
    check("fin_halt_data", imem_wdata, 32'hFFFF_FFFF);
    check("fin_count", word_count, 9'd6);

    do_start(8'hFE);
    make(15, 5'd3, 5'd4, 5'd0, 5'd0, 16'h1234, b, w, ok);
    push("cap0", b, w, ok, 8'hFE);
    make(23, 5'd6, 5'd7, 5'd0, 5'd0, 16'h0010, b, w, ok);
    push("cap1", b, w, ok, 8'hFF);
    check("cap_ready_drop", bus.req_ready, 1'b0);
    check("cap_term", state_o, 2'd2);
    @(negedge clk);
    check("cap_no_halt", imem_we, 1'b0);
    check("cap_done", state_o, 2'd3);
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    @(negedge clk);
    check("cap_fin_we", imem_we, 1'b0);
    check("cap_count", word_count, 9'd2);

    do_start(8'h20);
    wq.delete();
    err0    = n_err;
    exp_err = 0;
    stalls  = 0;
    a       = 8'h20;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 28);
      make(k, 5'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), 16'($urandom), b, w, ok);
      drive(b, 1'b1);
      if (!bus.req_ready) stalls++;
      if (ok) begin
        eq.push_back({a, w});
        a = a + 8'd1;
      end else begin
        exp_err++;
      end
      @(negedge clk);
    end
    drive('0, 1'b0);
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    eq.push_back({a, 32'hFFFF_FFFF});
    repeat (3) @(negedge clk);
    check("rnd_stalls", stalls, 0);
    check("rnd_nwords", wq.size(), eq.size());
    check("rnd_nerr", n_err - err0, exp_err);
    check("rnd_count", word_count, 9'(eq.size()));
    for (int i = 0; i < eq.size() && i < wq.size(); i++)
      check($sformatf("rnd_word%0d", i), wq[i], eq[i]);

    do_start(8'h40);
    make(5, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, b, w, ok);
    drive(b, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_state", state_o, 2'd0);
    check("mid_rst_ready", bus.req_ready, 1'b0);
    check("mid_rst_we", imem_we, 1'b0);
    check("mid_rst_addr", imem_addr, 8'h00);
    check("mid_rst_data", imem_wdata, 32'h0);
    check("mid_rst_count", word_count, 9'd0);
    wq.delete();
    repeat (2) @(negedge clk);
    check("mid_rst_nowrite", wq.size(), 0);
    reset = 1'b0;
    drive('0, 1'b0);
    @(negedge clk);
    check("mid_rst_idle", state_o, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
